player_fire_ctrl: RTL and testbench
===================================

# player_fire_ctrl

Downstream consumer of the keyboard tracker's `a`/`d`/`space` level outputs (hold mode). It converts held keys into a rate-limited, edge-clamped horizontal player position. It also issues bullet-spawn requests to the bullet engine over a req/ack handshake, with an enforced cooldown between shots. It sits between input decoding and the game-object logic that owns bullets and rendering.

## Interface
- `SCREEN_W`, 160: playfield width in pixels.
- `PLAYER_W`, 8: player sprite width in pixels.
- `X_START`, 76: player_x after reset.
- `MOVE_DIV`, 500000: clock cycles per 1-pixel step while a direction is held; must be ≥2.
- `FIRE_COOLDOWN`, 12500000: cycles after a fire acceptance before the next request may issue; must be ≥1.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-low.
- `a`  in  1  left key held (level, clock domain).
- `d`  in  1  right key held (level, clock domain).
- `space`  in  1  fire key held (level, clock domain).
- `fire_ack`  in  1  bullet engine accepts the pending request.
- `player_x`  out  8  left edge of the player, range 0..SCREEN_W-PLAYER_W.
- `fire_req`  out  1  bullet spawn request.
- `fire_x`  out  8  spawn column; stable while fire_req is high.
- `cooling`  out  1  high while the cooldown counter is running.

## Operation
- Reset (`reset`==0 at a clock edge) sets:
  - player_x=X_START, fire_req=0, fire_x=0, cooling=0.
  - move counter=0, cooldown counter=0, fire FSM=IDLE, armed=1.
  - Reset mid-request drops fire_req on that edge; no ack is owed.
- Direction: dir = left when a&~d, right when d&~a, none otherwise (both or neither).
- Move counter:
  - Increments each cycle while dir≠none.
  - Clears to 0 whenever dir==none or dir changes from the previous cycle.
  - On reaching MOVE_DIV-1, it wraps to 0 and player_x steps ±1.
- Clamp: a left step at 0 and a right step at SCREEN_W-PLAYER_W leave player_x unchanged. Arithmetic is unsigned 8-bit; no wrap-around.
- Fire FSM:
  - IDLE: if space & armed & ~cooling → REQ. Capture fire_x = player_x + PLAYER_W/2 (value before any same-cycle step). Set fire_req=1.
  - REQ: holds fire_req=1 and fire_x frozen until fire_ack==1. Then → COOL: fire_req=0, cooldown counter=FIRE_COOLDOWN-1, cooling=1.
  - COOL: the counter decrements each cycle. When it is 0 and still in COOL → IDLE with cooling=0.
- fire_ack outside REQ is ignored.
- Movement continues normally during REQ and COOL.

## Timing
- Step cadence: the first step occurs MOVE_DIV cycles after dir becomes non-none, then every MOVE_DIV cycles.
- Fire latency: space sampled high in IDLE at edge N → fire_req high after edge N.
- Ack: fire_ack sampled high at edge M → fire_req low and cooling high after edge M.
- Cooling lasts exactly FIRE_COOLDOWN cycles. The next fire_req can rise at the earliest FIRE_COOLDOWN+1 edges after M.
- Simultaneous step and fire capture: fire_x uses the pre-step player_x.

## Configuration
- `PLAYER_FIRE_AUTOREPEAT_EN` defined: armed is constantly 1. Holding space fires once per cooldown period.
- Not defined: armed clears on entering REQ and sets again only when space==0 is sampled in any state. One shot per press.

## Structure
- Shared package `block_shooter_pkg` holds:
  - COORD_W=8, SCREEN_W/PLAYER_W defaults.
  - Fire FSM state enum {IDLE, REQ, COOL}.
  - dir encoding {NONE, LEFT, RIGHT}.
- One sub-module, `tick_divider`: parameterised modulus, with `run` and `clear` inputs and a `tick` output. It is instantiated for the move cadence. The cooldown stays a plain down-counter in the FSM.

## Test plan
Bench parameters: MOVE_DIV=4, FIRE_COOLDOWN=8, X_START=76.
- Reset: hold reset=0 for 2 cycles with all keys high → player_x=76, fire_req=0, fire_x=0, cooling=0.
- Hold d for 12 cycles → player_x=79 (steps at cycles 4, 8, 12). Press a and d together for 20 cycles → no change.
- Start at X_START=150 and hold d for 40 cycles → player_x saturates at 152 and stays there. Separately, X_START=1 with a held → player_x=0 and stays.
- Space pulse at player_x=76; fire_ack delayed 5 cycles while d is held → fire_req high for 6 cycles, fire_x=80 throughout. fire_req drops the edge after ack; cooling=1 for 8 cycles.
- Space held continuously with macro defined → fire_req rises every ack+9 edges.
- Space held continuously with macro undefined → exactly one request. Release, then press → second request only after cooling ends.
- Assert reset during REQ → fire_req=0 next edge, FSM IDLE, and no further requests until space is sampled again.

Source files
------------

// File: rtl/block_shooter_pkg.sv
// block_shooter_pkg
//   Shared types and defaults for the block shooter game datapath.
//   - COORD_W            : width of every screen coordinate (8 bits)
//   - SCREEN_W_DEFAULT   : default playfield width in pixels
//   - PLAYER_W_DEFAULT   : default player sprite width in pixels
//   - fire_state_t       : fire handshake FSM states {IDLE, REQ, COOL}
//   - dir_t              : decoded horizontal direction {NONE, LEFT, RIGHT}
//   - decode_dir()       : maps held left/right keys to a dir_t
package block_shooter_pkg;

  localparam int COORD_W          = 8;
  localparam int SCREEN_W_DEFAULT = 160;
  localparam int PLAYER_W_DEFAULT = 8;

  typedef enum logic [1:0] {IDLE, REQ, COOL} fire_state_t;

  typedef enum logic [1:0] {NONE, LEFT, RIGHT} dir_t;

  // Both keys held cancel each other out, same as no key held.
  function automatic dir_t decode_dir(input logic left_key, input logic right_key);
    dir_t result;
    result = NONE;
    if (left_key && !right_key) result = LEFT;
    else if (right_key && !left_key) result = RIGHT;
    return result;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// tick_divider
//   Counts enabled cycles and emits a one-cycle tick on every MODULUS-th one.
//   Parameters:
//   - MODULUS : cycles per tick, must be >= 2
//   Ports:
//   - clock : system clock
//   - reset : synchronous, active-low
//   - run   : count this cycle
//   - clear : discard the accumulated count; the current cycle still counts if run is high
//   - tick  : high in the cycle that completes a full MODULUS-cycle period
module tick_divider #(
  parameter int MODULUS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (MODULUS > 1) ? $clog2(MODULUS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MODULUS - 1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] base;

  // Clearing restarts the period on this very cycle, so the first tick
  // lands exactly MODULUS cycles after a (re)start.
  always_comb begin
    base = clear ? '0 : count;
    tick = run && (base == LAST);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (!run || tick) begin
      count <= '0;
    end else begin
      count <= base + 1'b1;
    end
  end

endmodule

// File: rtl/player_fire_ctrl.sv
// player_fire_ctrl
//   Turns held a/d/space key levels into a rate-limited, edge-clamped player
//   position and rate-limited bullet spawn requests over a req/ack handshake.
//   Build option: define PLAYER_FIRE_AUTOREPEAT_EN to let a held fire key
//   fire once per cooldown; otherwise each press fires exactly once.
//   Parameters: SCREEN_W, PLAYER_W, X_START, MOVE_DIV (>=2), FIRE_COOLDOWN (>=1)
//   Ports:
//   - clock    : system clock
//   - reset    : synchronous, active-low
//   - a, d     : left / right key held
//   - space    : fire key held
//   - fire_ack : bullet engine accepts the pending request
//   - player_x : left edge of the player, 0..SCREEN_W-PLAYER_W
//   - fire_req : bullet spawn request
//   - fire_x   : spawn column, frozen while fire_req is high
//   - cooling  : high while the cooldown counter runs
module player_fire_ctrl
  import block_shooter_pkg::*;
#(
  parameter int SCREEN_W      = SCREEN_W_DEFAULT,
  parameter int PLAYER_W      = PLAYER_W_DEFAULT,
  parameter int X_START       = 76,
  parameter int MOVE_DIV      = 500000,
  parameter int FIRE_COOLDOWN = 12500000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               a,
  input  logic               d,
  input  logic               space,
  input  logic               fire_ack,
  output logic [COORD_W-1:0] player_x,
  output logic               fire_req,
  output logic [COORD_W-1:0] fire_x,
  output logic               cooling
);

  localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(SCREEN_W - PLAYER_W);
  localparam logic [COORD_W-1:0] X_INIT = COORD_W'(X_START);
  localparam logic [COORD_W-1:0] HALF_W = COORD_W'(PLAYER_W / 2);
  localparam int                 COOL_W = (FIRE_COOLDOWN > 1) ? $clog2(FIRE_COOLDOWN) : 1;
  localparam logic [COOL_W-1:0]  COOL_LOAD = COOL_W'(FIRE_COOLDOWN - 1);

  dir_t              dir;
  dir_t              prev_dir;
  logic              move_run;
  logic              move_clear;
  logic              step;
  fire_state_t       state;
  fire_state_t       next_state;
  logic [COOL_W-1:0] cool_count;
  logic              armed;
  logic              fire_start;

  assign dir        = decode_dir(a, d);
  assign move_run   = (dir != NONE);
  // A direction reversal restarts the cadence so the new direction waits a full period.
  assign move_clear = (dir == NONE) || (dir != prev_dir);
  assign fire_start = (state == IDLE) && (next_state == REQ);

  always_ff @(posedge clock) begin
    if (!reset) prev_dir <= NONE;
    else        prev_dir <= dir;
  end

  tick_divider #(
    .MODULUS (MOVE_DIV)
  ) u_move_div (
    .clock (clock),
    .reset (reset),
    .run   (move_run),
    .clear (move_clear),
    .tick  (step)
  );

  // Steps that would leave the playfield are dropped rather than wrapped.
  always_ff @(posedge clock) begin
    if (!reset) begin
      player_x <= X_INIT;
    end else if (step) begin
      if (dir == LEFT && player_x != '0)         player_x <= player_x - 1'b1;
      else if (dir == RIGHT && player_x < X_MAX) player_x <= player_x + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // IDLE is never cooling, so only arming gates a new request.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (space && armed) next_state = REQ;
      REQ:     if (fire_ack) next_state = COOL;
      COOL:    if (cool_count == '0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    fire_req = (state == REQ);
    cooling  = (state == COOL);
  end

  // fire_x is captured from the registered position, i.e. before any step
  // taking effect on the same edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      fire_x     <= '0;
      cool_count <= '0;
    end else begin
      if (fire_start) fire_x <= player_x + HALF_W;
      if (state == REQ && fire_ack)              cool_count <= COOL_LOAD;
      else if (state == COOL && cool_count != '0) cool_count <= cool_count - 1'b1;
    end
  end

`ifdef PLAYER_FIRE_AUTOREPEAT_EN
  assign armed = 1'b1;
`else
  // One shot per press: re-arm only once the key is seen released.
  always_ff @(posedge clock) begin
    if (!reset)          armed <= 1'b1;
    else if (!space)     armed <= 1'b1;
    else if (fire_start) armed <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_player_fire_ctrl.sv
// tb_player_fire_ctrl
//   Directed bench for player_fire_ctrl with MOVE_DIV=4, FIRE_COOLDOWN=8.
//   Three instances share all inputs and differ only in X_START (76, 150, 1)
//   so both clamp edges are exercised alongside the main instance.
module tb_player_fire_ctrl;

  logic       clock;
  logic       reset;
  logic       a;
  logic       d;
  logic       space;
  logic       fire_ack;
  logic [7:0] player_x;
  logic       fire_req;
  logic [7:0] fire_x;
  logic       cooling;
  logic [7:0] hi_x;
  logic       hi_req;
  logic [7:0] hi_fire_x;
  logic       hi_cooling;
  logic [7:0] lo_x;
  logic       lo_req;
  logic [7:0] lo_fire_x;
  logic       lo_cooling;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic a;
    logic d;
    int   cycles;
    int   exp_x;
    int   exp_hi;
    int   exp_lo;
  } move_vec_t;

  move_vec_t vecs[11];

  player_fire_ctrl #(
    .X_START(76), .MOVE_DIV(4), .FIRE_COOLDOWN(8)
  ) dut (
    .clock(clock), .reset(reset), .a(a), .d(d), .space(space), .fire_ack(fire_ack),
    .player_x(player_x), .fire_req(fire_req), .fire_x(fire_x), .cooling(cooling)
  );

  player_fire_ctrl #(
    .X_START(150), .MOVE_DIV(4), .FIRE_COOLDOWN(8)
  ) dut_hi (
    .clock(clock), .reset(reset), .a(a), .d(d), .space(space), .fire_ack(fire_ack),
    .player_x(hi_x), .fire_req(hi_req), .fire_x(hi_fire_x), .cooling(hi_cooling)
  );

  player_fire_ctrl #(
    .X_START(1), .MOVE_DIV(4), .FIRE_COOLDOWN(8)
  ) dut_lo (
    .clock(clock), .reset(reset), .a(a), .d(d), .space(space), .fire_ack(fire_ack),
    .player_x(lo_x), .fire_req(lo_req), .fire_x(lo_fire_x), .cooling(lo_cooling)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic apply_stimulus(input logic ka, input logic kd, input logic ks, input logic ack);
    a        = ka;
    d        = kd;
    space    = ks;
    fire_ack = ack;
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
    run_cycles(2);
    check_output("reset player_x", int'(player_x), 76);
    check_output("reset fire_req", int'(fire_req), 0);
    check_output("reset fire_x", int'(fire_x), 0);
    check_output("reset cooling", int'(cooling), 0);
    check_output("reset hi player_x", int'(hi_x), 150);
    check_output("reset lo player_x", int'(lo_x), 1);
    reset = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // a, d, cycles, main x, hi x, lo x (cumulative, hand-computed)
    vecs[0]  = '{1'b0, 1'b1, 3,  76,  150, 1};
    vecs[1]  = '{1'b0, 1'b1, 1,  77,  151, 2};
    vecs[2]  = '{1'b0, 1'b1, 8,  79,  152, 4};
    vecs[3]  = '{1'b1, 1'b1, 20, 79,  152, 4};
    vecs[4]  = '{1'b0, 1'b1, 3,  79,  152, 4};
    vecs[5]  = '{1'b1, 1'b0, 3,  79,  152, 4};
    vecs[6]  = '{1'b1, 1'b0, 1,  78,  151, 3};
    vecs[7]  = '{1'b0, 1'b0, 2,  78,  151, 3};
    vecs[8]  = '{1'b0, 1'b1, 40, 88,  152, 13};
    vecs[9]  = '{1'b1, 1'b0, 60, 73,  137, 0};
    vecs[10] = '{1'b0, 1'b1, 12, 76,  140, 3};

    run_cycles(1);
    do_reset();

    // Fire pulse with delayed ack while moving right.
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0);
    run_cycles(1);
    check_output("pulse fire_req rise", int'(fire_req), 1);
    check_output("pulse fire_x", int'(fire_x), 80);
    check_output("pulse cooling", int'(cooling), 0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      run_cycles(1);
      check_output("req held fire_req", int'(fire_req), 1);
      check_output("req held fire_x", int'(fire_x), 80);
    end
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1);
    run_cycles(1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    check_output("ack fire_req drop", int'(fire_req), 0);
    check_output("ack cooling", int'(cooling), 1);
    check_output("move during req", int'(player_x), 77);
    for (int k = 1; k < 8; k++) begin
      run_cycles(1);
      check_output("cooling window", int'(cooling), 1);
      check_output("no req in cool", int'(fire_req), 0);
    end
    run_cycles(1);
    check_output("cooling ends", int'(cooling), 0);
    check_output("idle no req", int'(fire_req), 0);
    check_output("move during cool", int'(player_x), 79);

    // Capture on the same edge as a step uses the pre-step position.
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0);
    run_cycles(1);
    check_output("step+fire fire_req", int'(fire_req), 1);
    check_output("step+fire fire_x", int'(fire_x), 83);
    check_output("step+fire player_x", int'(player_x), 80);

    // Keep space held through a whole cooldown.
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
    run_cycles(1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    check_output("held ack cooling", int'(cooling), 1);
    for (int k = 1; k < 8; k++) begin
      run_cycles(1);
      check_output("held cooling window", int'(cooling), 1);
    end
    run_cycles(1);
    check_output("held cooling ends", int'(cooling), 0);
    check_output("held no early req", int'(fire_req), 0);
    run_cycles(1);
`ifdef PLAYER_FIRE_AUTOREPEAT_EN
    check_output("autorepeat req at ack+9", int'(fire_req), 1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
    run_cycles(1);
    check_output("autorepeat ack", int'(fire_req), 0);
`else
    check_output("one shot no repeat", int'(fire_req), 0);
    for (int k = 0; k < 3; k++) begin
      run_cycles(1);
      check_output("one shot still idle", int'(fire_req), 0);
    end
`endif
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    run_cycles(9);
    check_output("settled fire_req", int'(fire_req), 0);
    check_output("settled cooling", int'(cooling), 0);

    // Release and re-press during cooldown: the next request waits for IDLE.
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    run_cycles(1);
    check_output("repress first req", int'(fire_req), 1);
    check_output("repress fire_x", int'(fire_x), 84);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
    run_cycles(1);
    check_output("repress ack", int'(fire_req), 0);
    for (int k = 1; k <= 9; k++) begin
      apply_stimulus(1'b0, 1'b0, (k == 1) ? 1'b0 : 1'b1, 1'b0);
      run_cycles(1);
      check_output("repress fire_req", int'(fire_req), (k == 9) ? 1 : 0);
      check_output("repress cooling", int'(cooling), (k < 8) ? 1 : 0);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    run_cycles(1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    run_cycles(9);

    // Reset while a request is pending.
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    run_cycles(1);
    check_output("pre-reset req", int'(fire_req), 1);
    reset = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    run_cycles(1);
    check_output("reset in req fire_req", int'(fire_req), 0);
    check_output("reset in req cooling", int'(cooling), 0);
    check_output("reset in req fire_x", int'(fire_x), 0);
    reset = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      run_cycles(1);
      check_output("stray ack ignored", int'(fire_req), 0);
      check_output("stray ack no cool", int'(cooling), 0);
    end
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    run_cycles(1);
    check_output("post-reset req", int'(fire_req), 1);
    check_output("post-reset fire_x", int'(fire_x), 80);

    // Movement vectors from a fresh reset.
    do_reset();
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].a, vecs[i].d, 1'b0, 1'b0);
      run_cycles(vecs[i].cycles);
      check_output($sformatf("vec%0d player_x", i), int'(player_x), vecs[i].exp_x);
      check_output($sformatf("vec%0d hi player_x", i), int'(hi_x), vecs[i].exp_hi);
      check_output($sformatf("vec%0d lo player_x", i), int'(lo_x), vecs[i].exp_lo);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
